// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one memory request port among NumPorts requesters
// and routes in-order responses back to the originating port via an ID FIFO.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no request pending; selection follows round-robin from rr_ptr
// ST_LOCK  | request issued but not granted; selection held on lock_sel_q
module mem_port_arbiter #(
    parameter int NumPorts     = 4,
    parameter int MemAddrWidth = 32,
    parameter int DataWidth    = 32,
    parameter int MaxRequests  = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumPorts-1:0]               slv_req_i,
    input  logic [NumPorts*MemAddrWidth-1:0]  slv_addr_i,
    input  logic [NumPorts-1:0]               slv_we_i,
    input  logic [NumPorts*DataWidth-1:0]     slv_wdata_i,
    input  logic [NumPorts*DataWidth/8-1:0]   slv_be_i,
    output logic [NumPorts-1:0]               slv_gnt_o,
    output logic [NumPorts-1:0]               slv_rsp_valid_o,
    output logic [DataWidth-1:0]              slv_rsp_rdata_o,
    output logic [NumPorts-1:0]               slv_rsp_error_o,
    output logic                              mem_req_o,
    output logic [MemAddrWidth-1:0]           mem_addr_o,
    output logic                              mem_we_o,
    output logic [DataWidth-1:0]              mem_wdata_o,
    output logic [DataWidth/8-1:0]            mem_be_o,
    input  logic                              mem_gnt_i,
    input  logic                              mem_rsp_valid_i,
    input  logic [DataWidth-1:0]              mem_rsp_rdata_i,
    input  logic                              mem_rsp_error_i,
    output logic [$clog2(MaxRequests):0]      outstanding_o,
    output logic                              unexpected_rsp_o
);

    localparam int PW = $clog2(NumPorts);
    localparam int AW = $clog2(MaxRequests);
    localparam int CW = AW + 1;
    localparam int BW = DataWidth / 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   lock_sel_q, lock_sel_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   id_q [MaxRequests];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            unexp_q;

    logic [PW-1:0]   sel;
    logic [PW-1:0]   head;
    logic            found;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    int              idx;

    assign fifo_full  = (count_q == CW'(MaxRequests));
    assign fifo_empty = (count_q == '0);
    assign head       = id_q[rd_ptr_q];

    // A held request keeps its port; if the locked port withdraws, fall back to round-robin.
    always_comb begin
        sel   = rr_ptr_q;
        found = 1'b0;
        idx   = 0;
        if (state_q == ST_LOCK && slv_req_i[lock_sel_q]) begin
            sel = lock_sel_q;
        end else begin
            for (int i = 0; i < NumPorts; i++) begin
                idx = (int'(rr_ptr_q) + i) % NumPorts;
                if (!found && slv_req_i[PW'(idx)]) begin
                    sel   = PW'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    assign mem_req_o   = (|slv_req_i) && !fifo_full;
    assign push        = mem_req_o && mem_gnt_i;
    assign pop         = mem_rsp_valid_i && !fifo_empty;
    assign mem_addr_o  = mem_req_o ? slv_addr_i[int'(sel)*MemAddrWidth +: MemAddrWidth] : '0;
    assign mem_we_o    = mem_req_o ? slv_we_i[sel] : 1'b0;
    assign mem_wdata_o = mem_req_o ? slv_wdata_i[int'(sel)*DataWidth +: DataWidth] : '0;
    assign mem_be_o    = mem_req_o ? slv_be_i[int'(sel)*BW +: BW] : '0;

    always_comb begin
        slv_gnt_o       = '0;
        slv_rsp_valid_o = '0;
        slv_rsp_error_o = '0;
        if (push) begin
            slv_gnt_o[sel] = 1'b1;
        end
        if (pop) begin
            slv_rsp_valid_o[head] = 1'b1;
            slv_rsp_error_o[head] = mem_rsp_error_i;
        end
    end

    assign slv_rsp_rdata_o  = mem_rsp_rdata_i;
    assign outstanding_o    = count_q;
    assign unexpected_rsp_o = unexp_q;

    always_comb begin
        state_d    = ST_IDLE;
        lock_sel_d = lock_sel_q;
        rr_ptr_d   = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (sel == PW'(NumPorts - 1)) ? '0 : sel + PW'(1);
        end else if (mem_req_o) begin
            state_d    = ST_LOCK;
            lock_sel_d = sel;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            lock_sel_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < MaxRequests; i++) begin
                id_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            unexp_q  <= 1'b0;
        end else begin
            if (push) begin
                id_q[wr_ptr_q] <= sel;
                wr_ptr_q       <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (mem_rsp_valid_i && fifo_empty) begin
                unexp_q <= 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: directed scenarios plus random traffic,
// all outputs compared against a queue-based reference model every cycle.
module tb_mem_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MR = 4;
    localparam int CW = $clog2(MR) + 1;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NP-1:0]     slv_req_i;
    logic [NP*AW-1:0]  slv_addr_i;
    logic [NP-1:0]     slv_we_i;
    logic [NP*DW-1:0]  slv_wdata_i;
    logic [NP*BW-1:0]  slv_be_i;
    logic [NP-1:0]     slv_gnt_o;
    logic [NP-1:0]     slv_rsp_valid_o;
    logic [DW-1:0]     slv_rsp_rdata_o;
    logic [NP-1:0]     slv_rsp_error_o;
    logic              mem_req_o;
    logic [AW-1:0]     mem_addr_o;
    logic              mem_we_o;
    logic [DW-1:0]     mem_wdata_o;
    logic [BW-1:0]     mem_be_o;
    logic              mem_gnt_i;
    logic              mem_rsp_valid_i;
    logic [DW-1:0]     mem_rsp_rdata_i;
    logic              mem_rsp_error_i;
    logic [CW-1:0]     outstanding_o;
    logic              unexpected_rsp_o;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(
        .NumPorts(NP), .MemAddrWidth(AW), .DataWidth(DW), .MaxRequests(MR)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .slv_req_i(slv_req_i), .slv_addr_i(slv_addr_i), .slv_we_i(slv_we_i),
        .slv_wdata_i(slv_wdata_i), .slv_be_i(slv_be_i), .slv_gnt_o(slv_gnt_o),
        .slv_rsp_valid_o(slv_rsp_valid_o), .slv_rsp_rdata_o(slv_rsp_rdata_o),
        .slv_rsp_error_o(slv_rsp_error_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_gnt_i(mem_gnt_i), .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rsp_rdata_i(mem_rsp_rdata_i), .mem_rsp_error_i(mem_rsp_error_i),
        .outstanding_o(outstanding_o), .unexpected_rsp_o(unexpected_rsp_o)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // requester side: each port holds its fields until granted
    bit            p_req   [NP];
    logic [AW-1:0] p_addr  [NP];
    logic          p_we    [NP];
    logic [DW-1:0] p_wdata [NP];
    logic [BW-1:0] p_be    [NP];

    // reference model: rr pointer, pending (locked) port, queue of outstanding IDs
    int m_rr;
    bit m_lock;
    int m_lsel;
    int m_q[$];
    bit m_unexp;

    task automatic model_reset();
        m_rr = 0; m_lock = 0; m_lsel = 0; m_unexp = 0;
        m_q.delete();
    endtask

    task automatic new_req(input int p);
        p_req[p]   = 1;
        p_addr[p]  = $urandom;
        p_we[p]    = 1'($urandom_range(0, 1));
        p_wdata[p] = $urandom;
        p_be[p]    = 4'($urandom_range(0, 15));
    endtask

    task automatic pack();
        for (int i = 0; i < NP; i++) begin
            slv_req_i[i]             = p_req[i];
            slv_addr_i[i*AW +: AW]   = p_addr[i];
            slv_we_i[i]              = p_we[i];
            slv_wdata_i[i*DW +: DW]  = p_wdata[i];
            slv_be_i[i*BW +: BW]     = p_be[i];
        end
    endtask

    function automatic int model_sel();
        if (m_lock && p_req[m_lsel]) return m_lsel;
        for (int i = 0; i < NP; i++) begin
            if (p_req[(m_rr + i) % NP]) return (m_rr + i) % NP;
        end
        return -1;
    endfunction

    // entered at a falling edge with inputs driven; returns at the next falling edge
    task automatic step();
        int s;
        bit ereq, hs, epop;
        logic [NP-1:0] egnt, ervld, eerr;
        pack();
        #1;
        s     = model_sel();
        ereq  = (s >= 0) && (m_q.size() < MR);
        hs    = ereq && mem_gnt_i;
        epop  = mem_rsp_valid_i && (m_q.size() > 0);
        egnt  = '0; ervld = '0; eerr = '0;
        if (hs) egnt[s] = 1'b1;
        if (epop) begin
            ervld[m_q[0]] = 1'b1;
            eerr[m_q[0]]  = mem_rsp_error_i;
        end
        check("gnt", slv_gnt_o, egnt);
        check("mem_req", mem_req_o, ereq);
        check("mem_addr", mem_addr_o, ereq ? p_addr[s] : '0);
        check("mem_we", mem_we_o, ereq ? p_we[s] : 1'b0);
        check("mem_wdata", mem_wdata_o, ereq ? p_wdata[s] : '0);
        check("mem_be", mem_be_o, ereq ? p_be[s] : '0);
        check("rsp_valid", slv_rsp_valid_o, ervld);
        check("rsp_error", slv_rsp_error_o, eerr);
        check("rsp_rdata", slv_rsp_rdata_o, mem_rsp_rdata_i);
        check("outstanding", outstanding_o, m_q.size());
        check("unexpected", unexpected_rsp_o, m_unexp);
        @(posedge clk_i);
        if (rst_i) begin
            model_reset();
        end else begin
            if (mem_rsp_valid_i) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_unexp = 1;
            end
            if (hs) begin
                m_q.push_back(s);
                m_rr   = (s + 1) % NP;
                m_lock = 0;
            end else begin
                m_lock = ereq;
                m_lsel = (s >= 0) ? s : 0;
            end
        end
        if (hs) p_req[s] = 0;
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        mem_gnt_i = 0; mem_rsp_valid_i = 0; mem_rsp_error_i = 0;
        mem_rsp_rdata_i = $urandom;
    endtask

    task automatic do_reset();
        rst_i = 1; model_reset();
        step();
        rst_i = 0;
    endtask

    initial begin
        for (int i = 0; i < NP; i++) begin
            p_req[i] = 0; p_addr[i] = '0; p_we[i] = 0; p_wdata[i] = '0; p_be[i] = '0;
        end
        rst_i = 1; model_reset(); idle_inputs(); pack();
        @(negedge clk_i);
        #1;
        check("rst_outstanding", outstanding_o, 0);
        check("rst_unexpected", unexpected_rsp_o, 0);
        check("rst_mem_req", mem_req_o, 0);
        step();
        rst_i = 0;

        // response with nothing outstanding
        mem_rsp_valid_i = 1; mem_rsp_error_i = 1;
        step();
        idle_inputs();
        step();
        check("unexp_sticky", unexpected_rsp_o, 1);
        do_reset();

        // ports 0 and 2 together, grant every cycle, response one cycle later
        new_req(0); new_req(2); mem_gnt_i = 1; pack();
        #1 check("rr_first_gnt", slv_gnt_o, 4'b0001);
        step();
        mem_rsp_valid_i = 1; pack();
        #1 check("rr_second_gnt", slv_gnt_o, 4'b0100);
        check("rsp_to_p0", slv_rsp_valid_o, 4'b0001);
        check("peak_outstanding", outstanding_o, 1);
        step();
        pack();
        #1 check("rsp_to_p2", slv_rsp_valid_o, 4'b0100);
        step();
        mem_rsp_valid_i = 0; new_req(0); new_req(3); pack();
        #1 check("rr_ptr_3", slv_gnt_o, 4'b1000);
        step();
        step();
        idle_inputs(); do_reset();

        // lock: port 1 waits three cycles while port 0 joins
        new_req(1); step();
        new_req(0); pack();
        #1 check("lock_addr", mem_addr_o, p_addr[1]);
        step();
        step();
        mem_gnt_i = 1; pack();
        #1 check("lock_gnt_p1", slv_gnt_o, 4'b0010);
        step();
        pack();
        #1 check("then_gnt_p0", slv_gnt_o, 4'b0001);
        step();
        idle_inputs(); do_reset();

        // fill the ID FIFO, then free one slot
        mem_gnt_i = 1;
        for (int i = 0; i < NP; i++) new_req(i);
        for (int i = 0; i < 4; i++) step();
        new_req(0); pack();
        #1 check("full_no_req", mem_req_o, 0);
        check("full_count", outstanding_o, 4);
        step();
        mem_rsp_valid_i = 1; pack();
        #1 check("full_pop_first", slv_rsp_valid_o, 4'b0001);
        check("full_still_blocked", slv_gnt_o, 4'b0000);
        step();
        mem_rsp_valid_i = 0; pack();
        #1 check("resume_gnt", slv_gnt_o, 4'b0001);
        step();
        idle_inputs(); do_reset();

        // simultaneous grant and response at two outstanding
        mem_gnt_i = 1; new_req(1); new_req(2);
        step(); step();
        new_req(3); mem_rsp_valid_i = 1; pack();
        #1 check("pp_rsp_head", slv_rsp_valid_o, 4'b0010);
        step();
        mem_rsp_valid_i = 0; mem_gnt_i = 0; pack();
        #1 check("pp_count", outstanding_o, 2);
        // third outstanding, last grant to port 2 leaves rr at 3
        mem_gnt_i = 1; new_req(2); step();
        mem_gnt_i = 0; step();
        check("three_outstanding", outstanding_o, 3);
        new_req(0); new_req(3); pack();
        rst_i = 1; model_reset();
        #1 check("async_rst_count", outstanding_o, 0);
        mem_gnt_i = 1; pack();
        #1 check("async_rst_rr", slv_gnt_o, 4'b0001);
        step();
        rst_i = 0; mem_gnt_i = 0;
        for (int i = 0; i < NP; i++) p_req[i] = 0;
        mem_rsp_valid_i = 1;
        step();
        check("post_rst_unexp", unexpected_rsp_o, 1);
        idle_inputs(); do_reset();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NP; i++) begin
                if (!p_req[i] && $urandom_range(0, 2) == 0) new_req(i);
            end
            mem_gnt_i       = 1'($urandom_range(0, 1));
            mem_rsp_valid_i = (m_q.size() > 0) ? ($urandom_range(0, 2) != 0)
                                                : ($urandom_range(0, 31) == 0);
            mem_rsp_error_i = 1'($urandom_range(0, 1));
            mem_rsp_rdata_i = $urandom;
            if ($urandom_range(0, 249) == 0) begin
                rst_i = 1; model_reset();
            end
            step();
            rst_i = 0;
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter NumPorts, default 4, number of memory-style requesters (2..16).
REQ-002 Parameter MemAddrWidth, default 32, request address width.
REQ-003 Parameter DataWidth, default 32, data width (multiple of 8).
REQ-004 Parameter MaxRequests, default 4, maximum outstanding granted requests (power of 2, >=2).
REQ-005 clk_i  in  1  sole clock; all state on rising edge.
REQ-006 rst_i  in  1  asynchronous, active-high reset.
REQ-007 slv_req_i  in  NumPorts  per-port request valid.
REQ-008 slv_addr_i  in  NumPorts*MemAddrWidth  per-port address, port i at slice i.
REQ-009 slv_we_i  in  NumPorts  per-port write enable.
REQ-010 slv_wdata_i  in  NumPorts*DataWidth  per-port write data.
REQ-011 slv_be_i  in  NumPorts*DataWidth/8  per-port byte enables.
REQ-012 slv_gnt_o  out  NumPorts  per-port grant, one-hot or zero.
REQ-013 slv_rsp_valid_o  out  NumPorts  per-port response valid, one-hot or zero.
REQ-014 slv_rsp_rdata_o  out  DataWidth  response data, broadcast to all ports.
REQ-015 slv_rsp_error_o  out  NumPorts  per-port response error, qualified by slv_rsp_valid_o.
REQ-016 mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o  out  1/MemAddrWidth/1/DataWidth/DataWidth/8  shared request to downstream memory-to-AXI bridge.
REQ-017 mem_gnt_i  in  1  downstream grant.
REQ-018 mem_rsp_valid_i, mem_rsp_rdata_i, mem_rsp_error_i  in  1/DataWidth/1  downstream in-order response.
REQ-019 outstanding_o  out  clog2(MaxRequests)+1  granted-but-unanswered request count.
REQ-020 unexpected_rsp_o  out  1  sticky flag: response received with no outstanding request.

Function
REQ-021 Arbitration SHALL be round-robin: search begins at rr_ptr, first port with slv_req_i high is selected.
REQ-022 mem_req_o SHALL equal (any slv_req_i high) AND NOT id-FIFO full; mem_addr/we/wdata/be SHALL be the selected port's fields, all zero when mem_req_o low.
REQ-023 slv_gnt_o[sel] SHALL equal mem_gnt_i AND mem_req_o; all other grant bits zero; combinational, zero latency.
REQ-024 Lock: once mem_req_o is high with selection sel and not granted, selection SHALL stay sel on following cycles until granted (no mid-request switch), even if higher-priority ports assert.
REQ-025 Requesters hold slv_req_i and fields stable until granted; withdrawal while locked is a protocol violation, arbiter clears lock and re-arbitrates next cycle.
REQ-026 On handshake (mem_req_o AND mem_gnt_i): push sel into id-FIFO (depth MaxRequests), rr_ptr <= (sel+1) mod NumPorts, clear lock.
REQ-027 FIFO full (MaxRequests outstanding): mem_req_o SHALL be low, no grants, even if a response pops the FIFO the same cycle.
REQ-028 On mem_rsp_valid_i with FIFO non-empty: slv_rsp_valid_o[head]=1, slv_rsp_error_o[head]=mem_rsp_error_i, pop FIFO same cycle; zero latency.
REQ-029 slv_rsp_rdata_o SHALL always equal mem_rsp_rdata_i.
REQ-030 mem_rsp_valid_i with FIFO empty (including same cycle as first push): no slv_rsp_valid_o, no pop, unexpected_rsp_o set and held until reset.
REQ-031 Simultaneous push and pop on non-full FIFO: both occur, outstanding_o unchanged.
REQ-032 FIFO pointers SHALL wrap modulo MaxRequests; count range 0..MaxRequests.

Reset
REQ-033 While rst_i high: rr_ptr=0, lock cleared, FIFO empty, outstanding_o=0, unexpected_rsp_o=0; grants, mem_req_o and response outputs follow the combinational rules with empty FIFO.
REQ-034 Reset mid-operation discards all outstanding IDs; responses arriving after reset count as unexpected.

Verification
REQ-035 Ports 0,2 request together, gnt_i=1 every cycle, rsp one cycle later -> grants 0 then 2, rr_ptr 3, responses routed to 0 then 2, outstanding_o peaks 1.
REQ-036 Port 1 requests, gnt_i low 3 cycles, port 0 asserts cycle 1 -> mem_addr_o stays port 1 until grant, then port 0 granted.
REQ-037 MaxRequests=4, 4 grants, no responses -> mem_req_o low, outstanding_o=4; one response -> routed to first ID, grant resumes next cycle.
REQ-038 mem_rsp_valid_i=1, error=1 with FIFO empty -> no slv_rsp_valid_o, unexpected_rsp_o=1 sticky.
REQ-039 Grant and response same cycle with outstanding_o=2 -> outstanding_o stays 2, response to head ID.
REQ-040 Assert rst_i with 3 outstanding -> outstanding_o=0, rr_ptr=0 immediately.
